mem_bridge: RTL and testbench
=============================

# mem_bridge

Load/store bridge between the KTC32 multicycle datapath and a 32-bit word-wide memory bus with a valid/ready handshake. Takes the controller's store code (`memwrite`) and load-extension code (`regwrite` encoding), converts a byte address into word address plus byte strobes, waits out bus wait-states, and returns sign/zero-extended load data. Raises `busy` so the controller holds its current state until `done`.

## Interface
- `TIMEOUT`, 255: bus wait-state limit in cycles; used only with `MEM_BRIDGE_TIMEOUT_EN`.
- `clk` in 1: the single clock.
- `reset` in 1: one clock; reset is synchronous and active-low (`reset`=0 resets on the `clk` edge).
- `req` in 1: start access; sampled only in IDLE.
- `memwrite` in 2: 00 load, 01 SB, 10 SH, 11 SW.
- `ldsize` in 3: 001 LBU, 010 LB, 011 LHU, 100 LH, 101 LW; ignored for stores.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: extended load data, held until the next `done`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; misalignment, illegal `ldsize`, or timeout.
- `bus_valid` out 1, `bus_we` out 1, `bus_addr` out 32 (bits [1:0]=00), `bus_wstrb` out 4, `bus_wdata` out 32.
- `bus_ready` in 1, `bus_rdata` in 32.

## Operation
- States: IDLE, BUS, RESP.
- IDLE + `req`: latch `memwrite`, `ldsize`, `addr`[1:0], and `wdata`.
  - Misaligned access (half with `addr`[0]=1; word with `addr`[1:0]≠00) or load with `ldsize` ∉ {001..101}: go to RESP with error set, no bus cycle.
  - Otherwise: go to BUS.
- BUS: `bus_valid`=1; `bus_addr`={addr[31:2],2'b00}; `bus_we`=(memwrite≠00).
  - SB: `bus_wstrb`=0001<<addr[1:0], byte replicated on all 4 lanes.
  - SH: `bus_wstrb`=0011<<addr[1:0], half replicated on both halves.
  - SW: `bus_wstrb`=1111.
  - Load: `bus_wstrb`=0000.
  - All bus outputs stay stable until `bus_ready`=1.
  - On `bus_ready`: capture `bus_rdata`, go to RESP.
- RESP: `done`=1, `err`=latched error, then go to IDLE.
- Load extraction, little-endian: byte lane = addr[1:0], half lane = addr[1].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: pass through.
  - `rdata` updates at the RESP entry edge only for a successful load.
  - Stores and errors leave `rdata` unchanged.
- `req` while `busy` is ignored, not queued.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `bus_valid`, `bus_we` = 0; `bus_wstrb` = 0000; `bus_addr`, `bus_wdata`, `rdata` = 0.
- All outputs are registered or decoded from state only. No combinational path from `req` or `bus_ready` to any output.
- `req` high in cycle 0 → `bus_valid` high in cycle 1.
- `bus_ready` high in cycle n (n≥1) → `done` high in cycle n+1, `bus_valid` low in cycle n+1.
- Zero-wait-state access: 3 cycles from `req` to `done`, inclusive.
- Error path: `done`+`err` in cycle 1.
- `bus_ready` outside BUS is ignored.
- Reset asserted mid-BUS: `bus_valid` drops on the next edge, no `done` is produced, and the bus transaction is abandoned.
- Back-to-back: a `req` in the `done` cycle is ignored. Earliest new accept is the cycle after `done`.

## Configuration
- `MEM_BRIDGE_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on BUS entry and increments each BUS cycle with `bus_ready`=0.
  - When the count reaches `TIMEOUT`, go to RESP with `err`=1 and drop `bus_valid`; `rdata` is unchanged.
  - `bus_ready` in the same cycle as the limit takes priority (normal completion).
- Undefined: no counter; BUS waits indefinitely; `TIMEOUT` unused.

## Test plan
- LW, addr 0x100, `bus_rdata`=0xDEADBEEF, `bus_ready` on first cycle → `bus_addr`=0x100, `bus_wstrb`=0000, `done` at cycle 2, `rdata`=0xDEADBEEF, `err`=0.
- LB vs LBU at addr 0x103, `bus_rdata`=0x80FF7F01 → LB `rdata`=0xFFFFFF80; LBU `rdata`=0x00000080.
- SH, addr 0x0E, `wdata`=0x0000ABCD, 3 wait states → `bus_wstrb`=1100, `bus_wdata`=0xABCDABCD held 4 cycles, `done` in cycle 5.
- SW at 0x102, then LH at 0x101 → each gives `done`+`err` in cycle 1 with no `bus_valid`; `rdata` unchanged.
- Reset low for one cycle during BUS wait → all outputs return to reset values; `bus_ready` in the following cycle gives no `done`; a new LW then completes normally.
- With `MEM_BRIDGE_TIMEOUT_EN`, `TIMEOUT`=4, `bus_ready` held 0 → `done`+`err` 5 cycles after `bus_valid` rises, then IDLE.

Source files
------------

// File: rtl/mem_bridge.sv
// Load/store bridge from the KTC32 multicycle controller to a word-wide valid/ready memory bus.
// Optional wait-state watchdog enabled by defining MEM_BRIDGE_TIMEOUT_EN (limit = TIMEOUT cycles).
module mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  ldsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  state_dbg
);

  // Bus handshake: bus_valid and all bus_* outputs stay stable from BUS entry until
  // the cycle bus_ready is seen high; that cycle completes the transfer.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUS = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  mw_q;
  logic [2:0]  ls_q;
  logic [1:0]  a_q;
  logic        err_q;

  logic        is_load, is_half, is_word, bad_ls, acc_err;
  logic [3:0]  strb_n;
  logic [31:0] wd_n;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_n;
  logic        tmo;

  assign is_load = (memwrite == 2'b00);
  assign is_half = (memwrite == 2'b10) || (is_load && (ldsize == 3'b011 || ldsize == 3'b100));
  assign is_word = (memwrite == 2'b11) || (is_load && ldsize == 3'b101);
  assign bad_ls  = is_load && (ldsize == 3'b000 || ldsize > 3'b101);
  assign acc_err = bad_ls || (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

  always_comb begin
    strb_n = 4'b0000;
    wd_n   = wdata;
    case (memwrite)
      2'b01: begin
        strb_n = 4'b0001 << addr[1:0];
        wd_n   = {4{wdata[7:0]}};
      end
      2'b10: begin
        strb_n = 4'b0011 << addr[1:0];
        wd_n   = {2{wdata[15:0]}};
      end
      2'b11: strb_n = 4'b1111;
      default: ;
    endcase
  end

  // Little-endian lane select from the latched low address bits.
  always_comb begin
    lane_b = 8'h00;
    case (a_q)
      2'd0: lane_b = bus_rdata[7:0];
      2'd1: lane_b = bus_rdata[15:8];
      2'd2: lane_b = bus_rdata[23:16];
      2'd3: lane_b = bus_rdata[31:24];
      default: ;
    endcase
    lane_h = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ls_q)
      3'b001:  ext_n = {24'h000000, lane_b};
      3'b010:  ext_n = {{24{lane_b[7]}}, lane_b};
      3'b011:  ext_n = {16'h0000, lane_h};
      3'b100:  ext_n = {{16{lane_h[15]}}, lane_h};
      default: ext_n = bus_rdata;
    endcase
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;

  // bus_ready wins over the limit in the same cycle.
  assign tmo = (state == S_BUS) && !bus_ready && (cnt == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_BUS && !bus_ready && !tmo) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = acc_err ? S_RESP : S_BUS;
      S_BUS:  if (bus_ready || tmo) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      mw_q      <= 2'b00;
      ls_q      <= 3'b000;
      a_q       <= 2'b00;
      err_q     <= 1'b0;
      rdata     <= 32'h0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (req) begin
            mw_q  <= memwrite;
            ls_q  <= ldsize;
            a_q   <= addr[1:0];
            err_q <= acc_err;
            if (!acc_err) begin
              bus_we    <= !is_load;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wstrb <= strb_n;
              bus_wdata <= wd_n;
            end
          end
        end
        S_BUS: begin
          if (bus_ready) begin
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            if (mw_q == 2'b00) rdata <= ext_n;
          end else if (tmo) begin
            err_q     <= 1'b1;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_RESP);
  assign err       = (state == S_RESP) && err_q;
  assign bus_valid = (state == S_BUS);
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: driver issues accesses and pushes expected responses,
// a done-triggered monitor pops and compares them.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  localparam int W = 49;  // {err, rdata, done cycle[15:0]}

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  memwrite = 2'b00;
  logic [2:0]  ldsize = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_x;

  mem_bridge #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .memwrite(memwrite), .ldsize(ldsize),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {31'h0, done}, 32'h0);
      end else begin
        mon_x = exp_q.pop_front();
        check("resp_err", {31'h0, err}, {31'h0, mon_x[48]});
        check("resp_rdata", rdata, mon_x[47:16]);
        check("resp_cycle", cyc, {16'h0, mon_x[15:0]});
      end
    end
  end

  // driver: one access; waits = bus wait states; hold keeps req high while busy
  task automatic access(input logic [1:0] mw, input logic [2:0] ls, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input logic e, input logic [31:0] exp_rd, input logic [3:0] strb,
                        input logic [31:0] bwd, input logic hold);
    int c0;
    @(negedge clk);
    req = 1'b1; memwrite = mw; ldsize = ls; addr = a; wdata = wd; bus_rdata = rd;
    c0 = cyc;
    exp_q.push_back({e, exp_rd, 16'(c0 + (e ? 1 : 2 + waits))});
    @(negedge clk);
    req = hold;
    if (hold) begin
      memwrite = 2'b11; addr = 32'h0000_0F00; wdata = 32'h5555_5555;
    end
    if (!e) begin
      for (int i = 0; i <= waits; i++) begin
        check("bus_valid", {31'h0, bus_valid}, 32'h1);
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_we", {31'h0, bus_we}, {31'h0, (mw != 2'b00)});
        check("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, strb});
        check("bus_wdata", bus_wdata, bwd);
        bus_ready = (i == waits);
        @(negedge clk);
      end
    end
    bus_ready = 1'b0;
    check("done_no_valid", {31'h0, bus_valid}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    check("idle_after_done", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_valid", {31'h0, bus_valid}, 32'h0);
    check("rst_wstrb", {28'h0, bus_wstrb}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b1;
    bus_ready = 1'b1;  // ready outside BUS is ignored
    @(negedge clk);
    bus_ready = 1'b0;
    check("ready_in_idle", {31'h0, busy}, 32'h0);

    //     mw     ls      addr          wdata         bus_rdata     w  e     exp rdata     strb     bus_wdata     hold
    access(2'b00, 3'b101, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0,        1'b0);
    access(2'b00, 3'b010, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,        1'b0);
    access(2'b00, 3'b001, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,        1'b0);
    access(2'b00, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 1, 1'b0, 32'hFFFF_80FF, 4'b0000, 32'h0,        1'b0);
    access(2'b00, 3'b011, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 0, 1'b0, 32'h0000_7F01, 4'b0000, 32'h0,        1'b0);
    access(2'b10, 3'b000, 32'h0000_000E, 32'h0000_ABCD, 32'h1111_1111, 3, 1'b0, 32'h0000_7F01, 4'b1100, 32'hABCD_ABCD, 1'b1);
    access(2'b01, 3'b000, 32'h0000_0005, 32'h1234_5678, 32'h0,        0, 1'b0, 32'h0000_7F01, 4'b0010, 32'h7878_7878, 1'b0);
    access(2'b11, 3'b000, 32'h0000_0102, 32'h1234_5678, 32'h0,        0, 1'b1, 32'h0000_7F01, 4'b0000, 32'h0,        1'b1);
    access(2'b00, 3'b100, 32'h0000_0101, 32'h0,        32'hFFFF_FFFF, 0, 1'b1, 32'h0000_7F01, 4'b0000, 32'h0,        1'b0);
    access(2'b00, 3'b110, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 0, 1'b1, 32'h0000_7F01, 4'b0000, 32'h0,        1'b0);
    access(2'b11, 3'b000, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,        1, 1'b0, 32'h0000_7F01, 4'b1111, 32'hCAFE_F00D, 1'b0);

    // reset during a BUS wait abandons the transaction
    @(negedge clk);
    req = 1'b1; memwrite = 2'b00; ldsize = 3'b101; addr = 32'h0000_0080; bus_rdata = 32'h9999_9999;
    @(negedge clk);
    req = 1'b0;
    check("mid_valid", {31'h0, bus_valid}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, bus_valid}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_addr", bus_addr, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    reset = 1'b1;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    check("mid_no_done", {31'h0, done}, 32'h0);
    access(2'b00, 3'b101, 32'h0000_0040, 32'h0, 32'h1122_3344, 0, 1'b0, 32'h1122_3344, 4'b0000, 32'h0, 1'b0);

`ifdef MEM_BRIDGE_TIMEOUT_EN
    begin
      int c0;
      @(negedge clk);
      req = 1'b1; memwrite = 2'b00; ldsize = 3'b101; addr = 32'h0000_0200; bus_rdata = 32'h7777_7777;
      c0 = cyc;
      exp_q.push_back({1'b1, 32'h1122_3344, 16'(c0 + 6)});
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 5; i++) begin
        check("tmo_valid", {31'h0, bus_valid}, 32'h1);
        @(negedge clk);
      end
      check("tmo_valid_drop", {31'h0, bus_valid}, 32'h0);
      @(negedge clk);
      check("tmo_idle", {31'h0, busy}, 32'h0);
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
